alu_ctrl_unit: RTL

- Upstream control stage for the 16-bit add/sub/xor ALU datapath.
- Accepts one instruction at a time over a valid/ready handshake and holds a small general-purpose register file.
- Sequences the ALU's operand-A register load, accumulator load and operation select, then writes the accumulator result back into the register file.
- Provides the ALU's a/b operands and all four of its control strobes.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/reg_file.sv | 37 +++
 rtl/alu_ctrl_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU control unit: opcodes, instruction field
// positions and the sequencer state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_MV  = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int OP_LO   = 12;
    localparam int RX_LO   = 9;
    localparam int RY_LO   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Opcodes that need the ALU (operand load + accumulate before write-back)
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, three
// combinational read ports (two operands plus debug).
module reg_file #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl_unit.sv
// Control stage for the add/sub/xor ALU: accepts instructions, sequences the
// ALU strobes and writes results back into the register file.
module alu_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [15:0]        instr,
    input  logic [WIDTH-1:0]   imm_data,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_a_en,
    output logic               alu_addsub,
    output logic               alu_xor,
    output logic               alu_acc_en,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [WIDTH-1:0]   dbg_data
);

    state_t              state;
    state_t              state_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [WIDTH-1:0]    imm_q;
    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   rx;
    logic [ADDR_W-1:0]   ry;
    logic                accept;
    logic                rf_we;
    logic [WIDTH-1:0]    rf_wdata;
    logic [WIDTH-1:0]    rf_a;
    logic [WIDTH-1:0]    rf_b;
    logic                unused_ir;

    assign op        = ir[OP_LO +: OP_W];
    assign rx        = ir[RX_LO +: ADDR_W];
    assign ry        = ir[RY_LO +: ADDR_W];
    assign unused_ir = ^ir[RY_LO-1:0];

    assign instr_ready = (state == ST_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir    <= instr;
                imm_q <= imm_data;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        done       = 1'b0;
        err        = 1'b0;
        alu_a_en   = 1'b0;
        alu_acc_en = 1'b0;
        alu_addsub = 1'b0;
        alu_xor    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = alu_result;
        case (state)
            ST_IDLE: begin
                // Decode from the incoming word: IR is only loaded on this edge
                if (accept) begin
                    state_nxt = is_alu_op(instr[OP_LO +: OP_W]) ? ST_LOAD_A : ST_WB;
                end
            end
            ST_LOAD_A: begin
                alu_a_en  = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                alu_acc_en = 1'b1;
                alu_addsub = (op == OP_SUB);
                alu_xor    = (op == OP_XOR);
                state_nxt  = ST_WB;
            end
            ST_WB: begin
                done      = 1'b1;
                err       = !is_legal_op(op);
                state_nxt = ST_IDLE;
                case (op)
                    OP_ADD, OP_SUB, OP_XOR: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_result;
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_q;
                    end
                    OP_MV: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_b;
                    end
                    default: begin
                        rf_we = 1'b0;
                    end
                endcase
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign alu_a = rf_a;
    assign alu_b = rf_b;

    reg_file #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rx),
        .wdata    (rf_wdata),
        .ra_addr  (rx),
        .ra_data  (rf_a),
        .rb_addr  (ry),
        .rb_data  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
